mem_load_ctrl: RTL

MEM_LOAD_CTRL -- requirements
Module: mem_load_ctrl

---
 rtl/mem_load_if.sv | 25 ++
 rtl/mem_load_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mem_load_if.sv
// Byte-stream and memory-write bundle for the memory load controller.
// The master drives the byte stream and abort and sees the memory side.
// The slave is the controller: it consumes bytes and produces writes and status.
interface mem_load_if;
   logic [7:0] byte_in;
   logic       byte_valid;
   logic       byte_ready;
   logic       abort;
   logic [7:0] mem_data;
   logic [7:0] mem_addr;
   logic       mem_we;
   logic       busy;
   logic       done;
   logic [1:0] err_code;

   modport master (
      output byte_in, byte_valid, abort,
      input  byte_ready, mem_data, mem_addr, mem_we, busy, done, err_code
   );

   modport slave (
      input  byte_in, byte_valid, abort,
      output byte_ready, mem_data, mem_addr, mem_we, busy, done, err_code
   );
endinterface

// File: rtl/mem_load_ctrl.sv
// Memory load controller: parses a byte stream of burst-write and clear-all
// commands and turns them into single-port memory writes. A burst is
// CMD_WRITE, start address, length, then length data bytes. A clear writes
// zero to every address, one per cycle. All outputs come from registers.
module mem_load_ctrl #(
   parameter int         MEM_DEPTH = 115,
   parameter logic [7:0] CMD_WRITE = 8'hA5,
   parameter logic [7:0] CMD_CLEAR = 8'hC3
) (
   input logic       clk,
   input logic       rst_n,
   mem_load_if.slave bus
);

   // Depth and last address held at 9 bits so MEM_DEPTH up to 256 still compares correctly.
   localparam logic [8:0] DEPTH_C = 9'(MEM_DEPTH);
   localparam logic [8:0] LAST_C  = 9'(MEM_DEPTH - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ADDR  = 3'd1,
      LEN   = 3'd2,
      DATA  = 3'd3,
      CLEAR = 3'd4
   } state_t;

   state_t     state_r;
   logic [7:0] start_r;
   logic [7:0] len_r;
   logic [7:0] idx_r;
   logic [8:0] clr_cnt_r;
   logic [7:0] mem_data_r;
   logic [7:0] mem_addr_r;
   logic       mem_we_r;
   logic       done_r;
   logic [1:0] err_r;
   logic       busy_r;
   logic       ready_r;

   logic       accept_s;
   logic [8:0] end_sum_s;

   // A byte is consumed only when offered and the controller is ready.
   assign accept_s  = bus.byte_valid & ready_r;
   // Burst end address computed without wrap so oversize bursts are caught.
   assign end_sum_s = {1'b0, start_r} + {1'b0, bus.byte_in};

   assign bus.byte_ready = ready_r;
   assign bus.mem_data   = mem_data_r;
   assign bus.mem_addr   = mem_addr_r;
   assign bus.mem_we     = mem_we_r;
   assign bus.busy       = busy_r;
   assign bus.done       = done_r;
   assign bus.err_code   = err_r;

   // Command FSM with registered write port, status and handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         start_r    <= 8'd0;
         len_r      <= 8'd0;
         idx_r      <= 8'd0;
         clr_cnt_r  <= 9'd0;
         mem_data_r <= 8'd0;
         mem_addr_r <= 8'd0;
         mem_we_r   <= 1'b0;
         done_r     <= 1'b0;
         err_r      <= 2'b00;
         busy_r     <= 1'b0;
         ready_r    <= 1'b1;
      end else begin
         // Write strobe and done are single-cycle unless re-asserted below.
         mem_we_r <= 1'b0;
         done_r   <= 1'b0;
         if (bus.abort) begin
            // Abort wins over any byte offered this cycle; error code is kept.
            state_r <= IDLE;
            busy_r  <= 1'b0;
            ready_r <= 1'b1;
         end else begin
            case (state_r)
               IDLE: begin
                  if (accept_s) begin
                     if (bus.byte_in == CMD_WRITE) begin
                        state_r <= ADDR;
                        busy_r  <= 1'b1;
                        err_r   <= 2'b00;
                     end else if (bus.byte_in == CMD_CLEAR) begin
                        // Address 0 is written straight away so the zero writes
                        // start the cycle after the command; the counter then
                        // points at the next address to clear.
                        state_r    <= CLEAR;
                        busy_r     <= 1'b1;
                        ready_r    <= 1'b0;
                        err_r      <= 2'b00;
                        mem_we_r   <= 1'b1;
                        mem_addr_r <= 8'd0;
                        mem_data_r <= 8'd0;
                        clr_cnt_r  <= 9'd1;
                        done_r     <= (DEPTH_C == 9'd1);
                     end else begin
                        err_r <= 2'b01;
                     end
                  end
               end
               ADDR: begin
                  if (accept_s) begin
                     start_r <= bus.byte_in;
                     if ({1'b0, bus.byte_in} >= DEPTH_C) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        err_r   <= 2'b10;
                     end else begin
                        state_r <= LEN;
                     end
                  end
               end
               LEN: begin
                  if (accept_s) begin
                     len_r <= bus.byte_in;
                     idx_r <= 8'd0;
                     if (bus.byte_in == 8'd0) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                     end else if (end_sum_s > DEPTH_C) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        err_r   <= 2'b11;
                     end else begin
                        state_r <= DATA;
                     end
                  end
               end
               DATA: begin
                  if (accept_s) begin
                     mem_we_r   <= 1'b1;
                     mem_data_r <= bus.byte_in;
                     mem_addr_r <= start_r + idx_r;
                     if (idx_r == (len_r - 8'd1)) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                     end else begin
                        idx_r <= idx_r + 8'd1;
                     end
                  end
               end
               CLEAR: begin
                  // Byte stream is stalled for the whole sweep, including the
                  // cycle carrying the final write and done.
                  if (clr_cnt_r == DEPTH_C) begin
                     state_r <= IDLE;
                     busy_r  <= 1'b0;
                     ready_r <= 1'b1;
                  end else begin
                     mem_we_r   <= 1'b1;
                     mem_addr_r <= clr_cnt_r[7:0];
                     mem_data_r <= 8'd0;
                     done_r     <= (clr_cnt_r == LAST_C);
                     clr_cnt_r  <= clr_cnt_r + 9'd1;
                  end
               end
               default: begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
                  ready_r <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule
